// File: rtl/htg_ad9213_mmcm_supervisor.sv
// rtl/htg_ad9213_mmcm_supervisor.sv - AD9213 sample-clock MMCM lock supervisor
// Pulses the MMCM reset, waits for a stable lock, holds downstream logic in reset until then.
module htg_ad9213_mmcm_supervisor #(
    parameter int RST_PULSE     = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mmcm_locked,
    input  logic             soft_reset,
    output logic             mmcm_rst,
    output logic             user_rst,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] lock_loss_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam int MAX_A = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
    localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int TW    = $clog2(MAX_P) + 1;

    localparam logic [TW-1:0] RST_LAST    = TW'(RST_PULSE - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] BLANK       = TW'(3);

    typedef enum logic [1:0] {
        S_RESET_MMCM = 2'd0,
        S_WAIT_LOCK  = 2'd1,
        S_STABILIZE  = 2'd2,
        S_RUN        = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic             sync1_q, locked_s_q;
    logic             mmcm_rst_q, user_rst_q, ready_q;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             loss_inc, tmo_inc;

    always_comb begin
        state_d  = state_q;
        loss_inc = 1'b0;
        tmo_inc  = 1'b0;
        case (state_q)
            S_RESET_MMCM: if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                // The first cycles only see stale synchronizer contents.
                if (cnt_q >= BLANK && locked_s_q) begin
                    state_d = S_STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_RESET_MMCM;
                    tmo_inc = !soft_reset;
                end
            end
            S_STABILIZE: begin
                if (!locked_s_q)                state_d = S_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)  state_d = S_RUN;
            end
            S_RUN: begin
                if (!locked_s_q) begin
                    state_d  = S_RESET_MMCM;
                    loss_inc = 1'b1;
                end
            end
            default: state_d = S_RESET_MMCM;
        endcase
        if (soft_reset) state_d = S_RESET_MMCM;

        // Re-entering RESET_MMCM via soft_reset also restarts the pulse.
        if (state_d != state_q || soft_reset) cnt_d = '0;
        else                                  cnt_d = cnt_q + TW'(1);

        loss_d = (loss_inc && loss_q != {CNT_W{1'b1}}) ? loss_q + CNT_W'(1) : loss_q;
        tmo_d  = (tmo_inc && tmo_q != {CNT_W{1'b1}}) ? tmo_q + CNT_W'(1) : tmo_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
            state_q    <= S_RESET_MMCM;
            cnt_q      <= '0;
            mmcm_rst_q <= 1'b1;
            user_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            loss_q     <= '0;
            tmo_q      <= '0;
        end else begin
            sync1_q    <= mmcm_locked;
            locked_s_q <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mmcm_rst_q <= (state_d == S_RESET_MMCM);
            user_rst_q <= (state_d != S_RUN);
            ready_q    <= (state_d == S_RUN);
            loss_q     <= loss_d;
            tmo_q      <= tmo_d;
        end
    end

    assign mmcm_rst        = mmcm_rst_q;
    assign user_rst        = user_rst_q;
    assign ready           = ready_q;
    assign state           = state_q;
    assign lock_loss_count = loss_q;
    assign timeout_count   = tmo_q;

endmodule

// File: tb/tb_htg_ad9213_mmcm_supervisor.sv
// tb/tb_htg_ad9213_mmcm_supervisor.sv - directed table plus randomized model-checked bench
module tb_htg_ad9213_mmcm_supervisor;

    localparam int RP = 4;
    localparam int LT = 32;
    localparam int SC = 8;
    localparam int CW = 4;

    localparam int PH_RESET = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_STAB  = 2;
    localparam int PH_RUN   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mmcm_locked = 1'b0;
    logic          soft_reset = 1'b0;
    logic          mmcm_rst, user_rst, ready;
    logic [1:0]    state;
    logic [CW-1:0] lock_loss_count, timeout_count;

    htg_ad9213_mmcm_supervisor #(
        .RST_PULSE(RP), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mmcm_locked(mmcm_locked), .soft_reset(soft_reset),
        .mmcm_rst(mmcm_rst), .user_rst(user_rst), .ready(ready), .state(state),
        .lock_loss_count(lock_loss_count), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase, the edge at which it was entered, and raw input history.
    int m_phase, m_entry, edge_n, m_ll, m_to;
    bit hist[$];

    function automatic logic [12:0] pack(int st, int ll, int to);
        logic [1:0] s;
        s = st[1:0];
        return {s, (st == PH_RESET), (st != PH_RUN), (st == PH_RUN), ll[3:0], to[3:0]};
    endfunction

    task automatic check(string name, logic [12:0] exp);
        logic [12:0] act;
        act = {state, mmcm_rst, user_rst, ready, lock_loss_count, timeout_count};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got state/rst/urst/rdy/ll/to=%h required %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_RESET;
        m_entry = edge_n;
        m_ll    = 0;
        m_to    = 0;
        hist.delete();
    endtask

    task automatic model_edge(bit lk, bit sr);
        int k, nxt;
        bit seen;
        edge_n++;
        hist.push_back(lk);
        seen = (hist.size() >= 3) ? hist[hist.size() - 3] : 1'b0;
        if (hist.size() > 3) void'(hist.pop_front());
        k   = edge_n - m_entry;
        nxt = m_phase;
        case (m_phase)
            PH_RESET: if (k >= RP) nxt = PH_WAIT;
            PH_WAIT: begin
                if (k > 3 && seen) nxt = PH_STAB;
                else if (k >= LT) begin
                    nxt = PH_RESET;
                    if (!sr && m_to < 15) m_to++;
                end
            end
            PH_STAB: begin
                if (!seen)        nxt = PH_WAIT;
                else if (k >= SC) nxt = PH_RUN;
            end
            default: begin
                if (!seen) begin
                    nxt = PH_RESET;
                    if (m_ll < 15) m_ll++;
                end
            end
        endcase
        if (sr) nxt = PH_RESET;
        if (nxt != m_phase || sr) m_entry = edge_n;
        m_phase = nxt;
    endtask

    task automatic cycle(bit lk, bit sr);
        mmcm_locked = lk;
        soft_reset  = sr;
        @(posedge clk);
        model_edge(lk, sr);
        #1;
        check($sformatf("model@edge%0d", edge_n), pack(m_phase, m_ll, m_to));
    endtask

    // Called between edges: outputs must take reset values before the next edge.
    task automatic async_reset(string name);
        rst_n = 1'b0;
        #1;
        model_reset();
        check(name, pack(PH_RESET, 0, 0));
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int cyc;
        bit arst;
        bit lk;
        bit sr;
        int st;
        int ll;
        int to;
    } vec_t;

    vec_t tbl[$];

    task automatic add(int cyc, bit arst, bit lk, bit sr, int st, int ll, int to);
        vec_t v;
        v.cyc = cyc; v.arst = arst; v.lk = lk; v.sr = sr; v.st = st; v.ll = ll; v.to = to;
        tbl.push_back(v);
    endtask

    initial begin
        int run_len;
        bit lvl;
        edge_n = 0;
        model_reset();

        // Timeout loop and saturation
        add(0, 1, 0, 0, 0, 0, 0);
        add(3, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0);
        add(31, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1);
        add(72, 0, 0, 0, 0, 0, 3);
        add(4, 0, 0, 0, 1, 0, 3);
        add(488, 0, 0, 0, 1, 0, 15);
        add(0, 1, 0, 0, 0, 0, 0);
        // Lock acquire at WAIT cycle 10
        add(4, 0, 0, 0, 1, 0, 0);
        add(9, 0, 0, 0, 1, 0, 0);
        add(1, 0, 1, 0, 1, 0, 0);
        add(1, 0, 1, 0, 1, 0, 0);
        add(1, 0, 1, 0, 2, 0, 0);
        add(7, 0, 1, 0, 2, 0, 0);
        add(1, 0, 1, 0, 3, 0, 0);
        // Lock loss in RUN and re-acquire
        add(5, 0, 1, 0, 3, 0, 0);
        add(1, 0, 0, 0, 3, 0, 0);
        add(1, 0, 1, 0, 3, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0);
        add(3, 0, 1, 0, 0, 1, 0);
        add(1, 0, 1, 0, 1, 1, 0);
        add(3, 0, 1, 0, 1, 1, 0);
        add(1, 0, 1, 0, 2, 1, 0);
        add(7, 0, 1, 0, 2, 1, 0);
        add(1, 0, 1, 0, 3, 1, 0);
        // soft_reset from RUN, then a 1-cycle glitch in STABILIZE cycle 5
        add(1, 0, 1, 1, 0, 1, 0);
        add(3, 0, 1, 0, 0, 1, 0);
        add(1, 0, 1, 0, 1, 1, 0);
        add(4, 0, 1, 0, 2, 1, 0);
        add(4, 0, 1, 0, 2, 1, 0);
        add(1, 0, 0, 0, 2, 1, 0);
        add(1, 0, 1, 0, 2, 1, 0);
        add(1, 0, 1, 0, 1, 1, 0);
        add(3, 0, 1, 0, 1, 1, 0);
        add(1, 0, 1, 0, 2, 1, 0);
        add(7, 0, 1, 0, 2, 1, 0);
        add(1, 0, 1, 0, 3, 1, 0);
        // Lock loss, then soft_reset coincident with timeout, then pulse restart
        add(2, 0, 0, 0, 3, 1, 0);
        add(1, 0, 0, 0, 0, 2, 0);
        add(3, 0, 0, 0, 0, 2, 0);
        add(1, 0, 0, 0, 1, 2, 0);
        add(31, 0, 0, 0, 1, 2, 0);
        add(1, 0, 0, 1, 0, 2, 0);
        add(2, 0, 0, 0, 0, 2, 0);
        add(1, 0, 0, 1, 0, 2, 0);
        add(3, 0, 0, 0, 0, 2, 0);
        add(1, 0, 0, 0, 1, 2, 0);
        // soft_reset coincident with lock loss in RUN
        add(3, 0, 1, 0, 1, 2, 0);
        add(1, 0, 1, 0, 2, 2, 0);
        add(7, 0, 1, 0, 2, 2, 0);
        add(1, 0, 1, 0, 3, 2, 0);
        add(2, 0, 0, 0, 3, 2, 0);
        add(1, 0, 0, 1, 0, 3, 0);
        // Async reset mid-STABILIZE
        add(3, 0, 1, 0, 0, 3, 0);
        add(1, 0, 1, 0, 1, 3, 0);
        add(4, 0, 1, 0, 2, 3, 0);
        add(2, 0, 1, 0, 2, 3, 0);
        add(0, 1, 1, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            if (tbl[i].arst) begin
                mmcm_locked = tbl[i].lk;
                async_reset($sformatf("vec%0d_arst", i));
            end else begin
                for (int c = 0; c < tbl[i].cyc; c++) cycle(tbl[i].lk, tbl[i].sr);
                check($sformatf("vec%0d", i), pack(tbl[i].st, tbl[i].ll, tbl[i].to));
            end
        end

        run_len = 0;
        lvl = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 999) == 0) begin
                async_reset($sformatf("rand_arst%0d", n));
            end else begin
                if (run_len == 0) begin
                    lvl     = ($urandom_range(0, 3) != 0);
                    run_len = $urandom_range(1, 60);
                end
                run_len--;
                cycle(lvl, ($urandom_range(0, 63) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
